int_ack_ctrl: RTL and testbench
===============================

Name: int_ack_ctrl

Overview:
Four-source interrupt controller, CPU side. Latches rising edges on four request lines into a pending register and gates them with per-source enables. Raises a single irq to the processor, answers the processor's ack with a vector and moves the winner to in-service, then retires the winner on eoi. Arbitration is fixed-priority or rotating, chosen by mode input m.

Parameters:
VEC_BASE, 8'h20, vector returned for source 0; source k returns VEC_BASE+k
SPUR_OFS, 4, offset of the spurious vector (VEC_BASE+SPUR_OFS)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
m  input  1  arbitration mode: 0 = fixed (source 0 highest), 1 = rotating
int_req  input  4  request lines, synchronous to clk; a 0->1 transition sets pending
en  input  4  per-source enable; 1 = source may win arbitration
ack  input  1  processor acknowledge, one-cycle pulse
eoi  input  1  end of interrupt, one-cycle pulse
irq  output  1  interrupt request to the processor
vec  output  8  vector, valid only while vec_valid=1
vec_valid  output  1  one-cycle strobe accompanying vec
pending  output  4  latched, not-yet-acknowledged requests
in_service  output  4  one-hot source being serviced, or 0

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; irq=0, vec=0, vec_valid=0, pending=0, in_service=0, rotation pointer=0, int_req history register=0. Reset asserted mid-service drops all state immediately.
- Edge detect: int_req_d registered every cycle. rise = int_req & ~int_req_d. pending[k] is set on rise[k], whether or not en[k] is set. A level held high does not re-set pending.
- Candidate set: cand = pending & en.
- Fixed mode (m=0): winner = lowest index in cand.
- Rotating mode (m=1): search starts at ptr and wraps modulo 4 (ptr, ptr+1, ...). ptr updates to (winner+1) mod 4 at eoi only. In fixed mode ptr holds its value.
- FSM states are IDLE, REQ and SERVE.
  - IDLE: when cand != 0, move to REQ. irq=1 from the next cycle on (irq is registered; one cycle of latency).
  - REQ: irq=1. On ack=1, the winner is computed from cand in that same cycle. Next cycle: vec=VEC_BASE+winner, vec_valid=1, pending[winner] cleared, in_service=onehot(winner), irq=0, state=SERVE.
  - REQ with ack and cand=0 (the source was masked or never enabled after irq rose): next cycle vec=VEC_BASE+SPUR_OFS, vec_valid=1, pending and in_service unchanged, state=IDLE.
  - REQ with no ack and cand falling to 0: irq stays 1 until ack. There is no silent retraction.
  - SERVE: irq=0 and no nesting. On eoi: in_service=0, ptr updated if m=1, state=IDLE. If cand != 0 in that cycle, irq rises one cycle after IDLE is entered (normal IDLE->REQ path).
- Simultaneous events:
  - rise[k] in the same cycle that pending[k] is cleared by ack: pending[k] ends at 1 (set wins).
  - ack outside REQ is ignored.
  - eoi outside SERVE is ignored.
  - ack and eoi in the same cycle: handled per the current state only.
- vec_valid lasts exactly one cycle. vec holds its last value afterwards.
- m may change at any time. It affects only the next arbitration.

Decomposition:
- Package int_ack_pkg holds the state encoding (IDLE=2'd0, REQ=2'd1, SERVE=2'd2), N_SRC=4, and the default VEC_BASE/SPUR_OFS.
- Sub-module prio_rr4 is natural: purely combinational. Inputs cand[3:0], ptr[1:0] and m. Outputs winner[1:0] and any. Instantiated once and unit-testable alone.

Test Plan:
- Reset: hold rst_n=0 with int_req=4'b1111 -> irq=0, pending=0, in_service=0, vec_valid=0. Release with int_req still high -> pending remains 0 (no rising edge).
- Fixed priority: m=0, en=4'b1111, int_req rises 4'b1010 -> pending=1010, irq=1 one cycle later. ack -> vec=8'h21, vec_valid for 1 cycle, in_service=0010, pending=1000. eoi -> irq re-raises. ack -> vec=8'h23.
- Rotating: m=1, ptr=0. Service source 0 to eoi, so ptr=1. Then raise sources 0 and 2 together and ack -> vec=8'h22 (source 2 beats 0). After eoi ptr=3, and the next ack -> vec=8'h20.
- Masking/spurious: en=4'b0001, int_req[3] rises -> pending[3]=1, irq stays 0. Set en=4'b1000 -> irq=1. Clear en to 0 before ack, then ack -> vec=8'h24 (spurious), pending[3] still 1, state IDLE.
- Simultaneous: int_req[1] re-rises in the ack cycle that selects source 1 -> in_service=0010 and pending[1]=1 afterwards. irq reasserts one cycle after eoi.
- Reset mid-SERVE: drive rst_n low while in_service=0100 -> all outputs zero asynchronously. Stray ack/eoi pulses in IDLE produce no vec_valid.

Source files
------------

// File: rtl/int_ack_pkg.sv
// Shared definitions for the four-source interrupt acknowledge controller.
package int_ack_pkg;
  localparam int N_SRC = 4;
  localparam logic [7:0] DEF_VEC_BASE = 8'h20;
  localparam int unsigned DEF_SPUR_OFS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } state_e;
endpackage

// File: rtl/int_ack_ctrl_prio_rr4.sv
// Four-way combinational arbiter: lowest index wins (m=0) or search from ptr with wrap (m=1).
module prio_rr4
  import int_ack_pkg::*;
(
  input  logic [3:0] cand,
  input  logic [1:0] ptr,
  input  logic       m,
  output logic [1:0] winner,
  output logic       any
);
  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx = m ? ptr + 2'(i) : 2'(i);
      if (cand[idx]) winner = idx;
    end
    any = |cand;
  end
endmodule

// File: rtl/int_ack_ctrl.sv
// Interrupt controller CPU side: edge-latched pending, irq/ack/vector handshake, eoi retire.
module int_ack_ctrl
  import int_ack_pkg::*;
#(
  parameter logic [7:0]  VEC_BASE = DEF_VEC_BASE,
  parameter int unsigned SPUR_OFS = DEF_SPUR_OFS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m,
  input  logic [3:0] int_req,
  input  logic [3:0] en,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [7:0] vec,
  output logic       vec_valid,
  output logic [3:0] pending,
  output logic [3:0] in_service
);
  state_e     state, state_n;
  logic [3:0] int_req_d, rise, cand, clr, pending_n, win_oh;
  logic [1:0] ptr, winner, svc_idx;
  logic       any, armed, take, retire;

  // History resets to 0, so the first cycle after reset only samples it;
  // a line already high at release is a level, not an edge.
  assign rise   = armed ? (int_req & ~int_req_d) : 4'b0000;
  assign cand   = pending & en;
  assign win_oh = 4'b0001 << winner;
  assign take   = (state == REQ) && ack;
  assign retire = (state == SERVE) && eoi;

  prio_rr4 u_arb (
    .cand   (cand),
    .ptr    (ptr),
    .m      (m),
    .winner (winner),
    .any    (any)
  );

  // A rise in the clearing cycle must survive, so set is applied after clear.
  always_comb begin
    clr       = (take && any) ? win_oh : 4'b0000;
    pending_n = (pending & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cand != 4'b0000) state_n = REQ;
      REQ:     if (ack) state_n = any ? SERVE : IDLE;
      SERVE:   if (eoi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    irq = (state == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      int_req_d  <= '0;
      pending    <= '0;
      in_service <= '0;
      svc_idx    <= '0;
      ptr        <= '0;
      vec        <= '0;
      vec_valid  <= 1'b0;
    end else begin
      armed     <= 1'b1;
      int_req_d <= int_req;
      pending   <= pending_n;
      vec_valid <= take;
      if (take) begin
        if (any) begin
          vec        <= VEC_BASE + {6'b0, winner};
          in_service <= win_oh;
          svc_idx    <= winner;
        end else begin
          vec <= VEC_BASE + 8'(SPUR_OFS);
        end
      end
      if (retire) begin
        in_service <= '0;
        if (m) ptr <= svc_idx + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_int_ack_ctrl.sv
// Directed bench for int_ack_ctrl: reset, fixed/rotating arbitration, masking, edge cases.
module tb_int_ack_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, m, ack, eoi;
  logic [3:0] int_req, en;
  logic       irq, vec_valid;
  logic [7:0] vec;
  logic [3:0] pending, in_service;
  int nchk = 0;
  int nerr = 0;

  int_ack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .m(m), .int_req(int_req), .en(en),
    .ack(ack), .eoi(eoi), .irq(irq), .vec(vec), .vec_valid(vec_valid),
    .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; m = 1'b0; ack = 1'b0; eoi = 1'b0;
    int_req = 4'b1111; en = 4'b1111;
    tick(); tick();
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_pend", {4'b0, pending}, 8'h00);
    chk("rst_insvc", {4'b0, in_service}, 8'h00);
    chk("rst_vv", {7'b0, vec_valid}, 8'h00);
    chk("rst_vec", vec, 8'h00);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("rel_pend", {4'b0, pending}, 8'h00);
    chk("rel_irq", {7'b0, irq}, 8'h00);
    int_req = 4'b0000; tick();

    // Fixed priority
    int_req = 4'b1010; tick();
    chk("fx_pend", {4'b0, pending}, 8'h0a);
    chk("fx_irq0", {7'b0, irq}, 8'h00);
    tick();
    chk("fx_irq1", {7'b0, irq}, 8'h01);
    pulse_ack();
    chk("fx_vec1", vec, 8'h21);
    chk("fx_vv1", {7'b0, vec_valid}, 8'h01);
    chk("fx_insvc1", {4'b0, in_service}, 8'h02);
    chk("fx_pend1", {4'b0, pending}, 8'h08);
    chk("fx_irqsv", {7'b0, irq}, 8'h00);
    pulse_ack(); // ignored in SERVE
    chk("fx_vvdrop", {7'b0, vec_valid}, 8'h00);
    chk("fx_vechold", vec, 8'h21);
    pulse_eoi();
    chk("fx_insvc0", {4'b0, in_service}, 8'h00);
    chk("fx_irqlat", {7'b0, irq}, 8'h00);
    tick();
    chk("fx_irqre", {7'b0, irq}, 8'h01);
    pulse_ack();
    chk("fx_vec3", vec, 8'h23);
    chk("fx_insvc3", {4'b0, in_service}, 8'h08);
    pulse_eoi();
    int_req = 4'b0000; tick();

    // Rotating: serve 0 -> ptr=1
    m = 1'b1;
    int_req = 4'b0001; tick(); tick();
    pulse_ack();
    chk("rr_vec0", vec, 8'h20);
    pulse_eoi();
    int_req = 4'b0000; tick();
    int_req = 4'b0101; tick(); tick();
    chk("rr_irq", {7'b0, irq}, 8'h01);
    pulse_ack();
    chk("rr_vec2", vec, 8'h22);
    chk("rr_pend", {4'b0, pending}, 8'h01);
    pulse_eoi(); // ptr -> 3
    tick();
    pulse_ack();
    chk("rr_wrap", vec, 8'h20);
    pulse_eoi();
    int_req = 4'b0000; tick();

    // Masking and spurious vector
    m = 1'b0; en = 4'b0001;
    int_req = 4'b1000; tick();
    chk("mk_pend", {4'b0, pending}, 8'h08);
    tick(); tick();
    chk("mk_irq0", {7'b0, irq}, 8'h00);
    en = 4'b1000; tick();
    chk("mk_irq1", {7'b0, irq}, 8'h01);
    en = 4'b0000; tick();
    chk("mk_hold", {7'b0, irq}, 8'h01);
    pulse_ack();
    chk("sp_vec", vec, 8'h24);
    chk("sp_vv", {7'b0, vec_valid}, 8'h01);
    chk("sp_pend", {4'b0, pending}, 8'h08);
    chk("sp_insvc", {4'b0, in_service}, 8'h00);
    tick();
    chk("sp_idle", {7'b0, irq}, 8'h00);
    int_req = 4'b0000; tick();

    // Re-rise of the winner in its ack cycle
    en = 4'b0010;
    int_req = 4'b0010; tick(); tick();
    int_req = 4'b0000; tick();
    int_req = 4'b0010; ack = 1'b1; tick(); ack = 1'b0;
    chk("sim_insvc", {4'b0, in_service}, 8'h02);
    chk("sim_pend", {4'b0, pending}, 8'h0a);
    chk("sim_vec", vec, 8'h21);
    pulse_eoi();
    chk("sim_irq0", {7'b0, irq}, 8'h00);
    tick();
    chk("sim_irq1", {7'b0, irq}, 8'h01);
    pulse_ack();
    pulse_eoi();

    // Reset while serving source 2
    en = 4'b0100; int_req = 4'b0110; tick(); tick();
    pulse_ack();
    chk("ms_insvc", {4'b0, in_service}, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_insvc", {4'b0, in_service}, 8'h00);
    chk("ar_pend", {4'b0, pending}, 8'h00);
    chk("ar_vec", vec, 8'h00);
    chk("ar_vv", {7'b0, vec_valid}, 8'h00);
    chk("ar_irq", {7'b0, irq}, 8'h00);
    tick();
    rst_n = 1'b1; int_req = 4'b0000; tick();
    pulse_ack();
    chk("st_ack", {7'b0, vec_valid}, 8'h00);
    pulse_eoi();
    chk("st_eoi", {7'b0, vec_valid}, 8'h00);
    chk("st_irq", {7'b0, irq}, 8'h00);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
